// File: rtl/cache_pkg.sv
// Shared types for the direct-mapped cache controller: FSM state encoding and tag-width helper.
package cache_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StRead,
    StReadMiss,
    StReadMem,
    StReadData,
    StWrite,
    StWriteMiss,
    StWriteHit,
    StWriteMem,
    StWriteData,
    StEvict,
    StEvictMem
  } state_e;

  function automatic int unsigned tag_w(input int unsigned addr_w, input int unsigned index_w);
    return addr_w - index_w;
  endfunction

endpackage

// File: rtl/mem_lat_ctr.sv
// Memory-latency down-counter: loaded with MEM_LAT-1 on a memory strobe, counts down to zero.
module mem_lat_ctr #(
  parameter int unsigned MEM_LAT = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o
);

  localparam int unsigned CntW = $clog2(MEM_LAT + 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= CntW'(MEM_LAT - 1);
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CntW'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/cache_ctrl_fsm.sv
// Direct-mapped cache controller with tag/valid store, request FSM and hit/miss counters.
// Define CACHE_WB_EN for write-back/write-allocate with per-line dirty bits and eviction.
module cache_ctrl_fsm
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned INDEX_W = 4,
  parameter int unsigned MEM_LAT = 4,
  parameter int unsigned PERF_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              strobe,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  output logic              rdy,
  output logic              w,
  output logic              wsel,
  output logic              rsel,
  output logic              mstrobe,
  output logic              mrw,
  output logic [ADDR_W-1:0] maddr,
  output logic [PERF_W-1:0] hit_cnt,
  output logic [PERF_W-1:0] miss_cnt
);

  localparam int unsigned TAG_W = tag_w(ADDR_W, INDEX_W);
  localparam int unsigned LINES = 2 ** INDEX_W;

  state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              rw_q;
  logic [TAG_W-1:0]  tag_q [LINES];
  logic [LINES-1:0]  valid_q;

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   addr_tag;
  logic               hit, accept, fill, count_hit, count_miss, cnt_dec, cnt_zero;

  assign idx      = addr_q[INDEX_W-1:0];
  assign addr_tag = addr_q[ADDR_W-1:INDEX_W];
  assign hit      = valid_q[idx] && (tag_q[idx] == addr_tag);

`ifdef CACHE_WB_EN
  logic [LINES-1:0] dirty_q;
  logic             set_dirty, clr_dirty, victim_dirty;
  assign victim_dirty = valid_q[idx] && dirty_q[idx];
`endif

  always_comb begin
    state_d    = state_q;
    rdy        = 1'b0;
    w          = 1'b0;
    wsel       = 1'b0;
    rsel       = 1'b0;
    mstrobe    = 1'b0;
    mrw        = 1'b0;
    maddr      = '0;
    accept     = 1'b0;
    fill       = 1'b0;
    count_hit  = 1'b0;
    count_miss = 1'b0;
    cnt_dec    = 1'b0;
`ifdef CACHE_WB_EN
    set_dirty  = 1'b0;
    clr_dirty  = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        if (strobe) begin
          accept  = 1'b1;
          state_d = rw ? StWrite : StRead;
        end
      end
      StRead: begin
        count_hit  = hit;
        count_miss = !hit;
        if (hit) begin
          rdy     = 1'b1;
          state_d = StIdle;
        end else begin
`ifdef CACHE_WB_EN
          state_d = victim_dirty ? StEvict : StReadMiss;
`else
          state_d = StReadMiss;
`endif
        end
      end
      // mrw follows the latched CPU direction for the CPU's own memory access.
      StReadMiss: begin
        mstrobe = 1'b1;
        mrw     = rw_q;
        maddr   = addr_q;
        state_d = StReadMem;
      end
      StReadMem: begin
        mrw     = rw_q;
        maddr   = addr_q;
        cnt_dec = 1'b1;
        if (cnt_zero) state_d = StReadData;
      end
      StReadData: begin
        w       = 1'b1;
        wsel    = 1'b1;
        rsel    = 1'b1;
        rdy     = 1'b1;
        fill    = 1'b1;
`ifdef CACHE_WB_EN
        clr_dirty = 1'b1;
`endif
        state_d = StIdle;
      end
      StWrite: begin
        count_hit  = hit;
        count_miss = !hit;
`ifdef CACHE_WB_EN
        state_d = hit ? StWriteHit : (victim_dirty ? StEvict : StWriteMiss);
`else
        state_d = hit ? StWriteHit : StWriteMiss;
`endif
      end
`ifdef CACHE_WB_EN
      StWriteHit: begin
        w         = 1'b1;
        set_dirty = 1'b1;
        rdy       = 1'b1;
        state_d   = StIdle;
      end
      StWriteMiss: begin
        w         = 1'b1;
        fill      = 1'b1;
        set_dirty = 1'b1;
        rdy       = 1'b1;
        state_d   = StIdle;
      end
`else
      StWriteHit: begin
        w       = 1'b1;
        mstrobe = 1'b1;
        mrw     = rw_q;
        maddr   = addr_q;
        state_d = StWriteMem;
      end
      StWriteMiss: begin
        mstrobe = 1'b1;
        mrw     = rw_q;
        maddr   = addr_q;
        state_d = StWriteMem;
      end
`endif
      StWriteMem: begin
        mrw     = rw_q;
        maddr   = addr_q;
        cnt_dec = 1'b1;
        if (cnt_zero) state_d = StWriteData;
      end
      StWriteData: begin
        rdy     = 1'b1;
        state_d = StIdle;
      end
`ifdef CACHE_WB_EN
      StEvict: begin
        mstrobe = 1'b1;
        mrw     = 1'b1;
        maddr   = {tag_q[idx], idx};
        state_d = StEvictMem;
      end
      StEvictMem: begin
        mrw     = 1'b1;
        maddr   = {tag_q[idx], idx};
        cnt_dec = 1'b1;
        if (cnt_zero) begin
          clr_dirty = 1'b1;
          state_d   = rw_q ? StWriteMiss : StReadMiss;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      rw_q     <= 1'b0;
      valid_q  <= '0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q <= addr;
        rw_q   <= rw;
      end
      if (fill) valid_q[idx] <= 1'b1;
      if (count_hit && (hit_cnt != '1)) hit_cnt <= hit_cnt + PERF_W'(1);
      if (count_miss && (miss_cnt != '1)) miss_cnt <= miss_cnt + PERF_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && fill) tag_q[idx] <= addr_tag;
  end

`ifdef CACHE_WB_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      dirty_q <= '0;
    end else if (set_dirty) begin
      dirty_q[idx] <= 1'b1;
    end else if (clr_dirty) begin
      dirty_q[idx] <= 1'b0;
    end
  end
`endif

  mem_lat_ctr #(
    .MEM_LAT(MEM_LAT)
  ) u_mem_lat_ctr (
    .clk_i  (clk),
    .reset_i(reset),
    .load_i (mstrobe),
    .dec_i  (cnt_dec),
    .zero_o (cnt_zero)
  );

endmodule
